fib_arbiter: RTL and testbench
==============================

Name: fib_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one `fib` engine (strobe/busy iterative Fibonacci core) between NREQ requesters.
- Accepts one request at a time and range-checks n against MAX_N.
- Launches the engine with a one-cycle strobe, waits for busy to drop, then returns F(n) with a one-cycle ack to the granted requester.
- Sits between the requester-side blocks and a single `fib` instance; the engine is instantiated by the parent, not inside this block.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 32, data width of n and of the result; must equal the engine's WIDTH.
- MAX_N, 47, largest legal n; F(47)=2971215073 is the last value that fits in 32 bits.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  reset, asynchronous, active-high.
- i_req  in  NREQ  per-requester request level; held high until the matching ack.
- i_n  in  NREQ*WIDTH  packed per-requester n; slice k = bits [k*WIDTH +: WIDTH]; stable while i_req[k] is high.
- o_ack  out  NREQ  one-cycle completion pulse; at most one bit set.
- o_result  out  WIDTH  F(n), valid while any o_ack bit is high.
- o_err  out  1  high together with o_ack when the request was rejected because n > MAX_N.
- o_busy  out  1  high in every state except IDLE.
- o_eng_stb  out  1  start strobe to the engine (engine i_stb).
- o_eng_n  out  WIDTH  n for the engine (engine i_n); holds the latched n.
- i_eng_busy  in  1  engine o_busy.
- i_eng_fib  in  WIDTH  engine o_fib.

Behaviour:
- Reset (async, active-high): state=IDLE, rr pointer=0, latched index=0, latched n=0. All outputs 0: o_ack, o_result, o_err, o_busy, o_eng_stb, o_eng_n.
- All outputs are registered.
- States: IDLE, STROBE, SETTLE, WAIT, DONE.
- IDLE:
  - If any i_req bit is set and i_eng_busy=0, pick the winner round-robin: first set bit at or after the rr pointer, wrapping.
  - Latch the winner's index and its n slice.
  - If n > MAX_N (unsigned compare) -> DONE with err=1, result=0.
  - Otherwise -> STROBE.
  - If i_eng_busy=1 (engine still running, e.g. after a reset of this block only), stay in IDLE.
- STROBE: o_eng_stb=1 for exactly this one cycle; o_eng_n=latched n -> SETTLE.
- SETTLE: one unconditional cycle while the engine loads -> WAIT.
- WAIT: when i_eng_busy=0, capture i_eng_fib into the result register -> DONE; otherwise stay.
- DONE:
  - o_ack[latched index]=1, o_result valid, o_err as decided in IDLE.
  - rr pointer := (latched index + 1) mod NREQ.
  - -> IDLE.
  - o_result and o_err return to 0 the following cycle.
- Latency, counted from the first IDLE cycle in which the request is seen:
  - Valid n: ack in cycle max(n,1)+3. n=0 -> 4, n=1 -> 4, n=10 -> 13.
  - Rejected n: ack in cycle 1.
- Requester rule: deassert i_req[k] in the cycle after the ack is seen. The rr pointer moves past k, so a held request never starves the others.
- A requester that drops i_req mid-operation is not aborted; the sequence completes and the ack still pulses.
- Changing i_n[k] after the grant has no effect, because n is latched in IDLE.
- Requests arriving during non-IDLE states wait.
- Requests arriving in the same cycle are resolved by the rr pointer only.
- Reset mid-operation: return to IDLE immediately with no ack. The engine shares the reset, so it is idle afterwards.
- No arithmetic beyond the unsigned compare and the modulo-NREQ pointer increment.

Decomposition:
- Shared package fib_pkg:
  - Arbiter state enum.
  - FIB_WIDTH_DEFAULT=32.
  - FIB_MAX_N_32=47.
- One natural sub-module: rr_pick. Combinational; inputs request vector and pointer; outputs any, one-hot grant and index.

Test Plan:
- Single request: req0 with n=10 -> o_ack[0] pulse in cycle 13, o_result=55, o_err=0.
- Boundary n: n=0 -> result 0 at cycle 4; n=1 -> result 1 at cycle 4; n=47 -> result 2971215073 (0xB11924E1).
- Out of range: n=48 on req2 -> o_ack[2] pulse at cycle 1, o_err=1, o_result=0, and o_eng_stb never asserts.
- Round-robin: req0..req3 all high with n=5,6,7,8, each dropped after its ack -> acks in order 0,1,2,3 with results 5,8,13,21. Repeat with the pointer at 2 -> order 2,3,0,1.
- Fairness: req0 continuously re-requesting with req1 also high -> grants alternate 0,1,0,1.
- Reset mid-WAIT: req1 with n=20, reset asserted at cycle 8 -> no ack, all outputs 0 during reset. A new req1 with n=20 after release -> result 6765 at cycle 23.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci engine arbiter.
package fib_pkg;

    localparam int FIB_WIDTH_DEFAULT = 32;
    localparam int FIB_MAX_N_32      = 47;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STROBE,
        ST_SETTLE,
        ST_WAIT,
        ST_DONE
    } arb_state_e;

endpackage

// File: rtl/fib_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after the pointer, wrapping.
module rr_pick
    import fib_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDXW-1:0] i_ptr,
    output logic            o_any,
    output logic [NREQ-1:0] o_grant,
    output logic [IDXW-1:0] o_idx
);

    int pos;

    // Scan from the farthest position back to the pointer so the closest one wins
    always_comb begin
        o_any   = 1'b0;
        o_grant = '0;
        o_idx   = '0;
        pos     = 0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            pos = int'(i_ptr) + j;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            if (i_req[pos]) begin
                o_any        = 1'b1;
                o_idx        = IDXW'(pos);
                o_grant      = '0;
                o_grant[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fib_arbiter.sv
// Shares one strobe/busy Fibonacci engine between NREQ requesters.
module fib_arbiter
    import fib_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = FIB_WIDTH_DEFAULT,
    parameter int MAX_N = FIB_MAX_N_32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [NREQ-1:0]       i_req,
    input  logic [NREQ*WIDTH-1:0] i_n,
    output logic [NREQ-1:0]       o_ack,
    output logic [WIDTH-1:0]      o_result,
    output logic                  o_err,
    output logic                  o_busy,
    output logic                  o_eng_stb,
    output logic [WIDTH-1:0]      o_eng_n,
    input  logic                  i_eng_busy,
    input  logic [WIDTH-1:0]      i_eng_fib
);

    localparam int IDXW = $clog2(NREQ);

    arb_state_e       state_q, state_d;
    logic [IDXW-1:0]  ptr_q, ptr_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic             stb_q, stb_d;
    logic             busy_q, busy_d;

    logic             pick_any;
    logic [NREQ-1:0]  pick_grant;
    logic [IDXW-1:0]  pick_idx;
    logic [WIDTH-1:0] pick_n;

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_pick (
        .i_req   (i_req),
        .i_ptr   (ptr_q),
        .o_any   (pick_any),
        .o_grant (pick_grant),
        .o_idx   (pick_idx)
    );

    // Select the winning requester's n slice through the one-hot grant
    always_comb begin
        pick_n = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (pick_grant[k]) begin
                pick_n = i_n[k*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state and next-output logic for the grant/launch/wait/ack sequence
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        n_d      = n_q;
        result_d = result_q;
        err_d    = err_q;
        ack_d    = '0;
        stb_d    = 1'b0;
        busy_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_any && !i_eng_busy) begin
                    idx_d = pick_idx;
                    n_d   = pick_n;
                    if (pick_n > WIDTH'(MAX_N)) begin
                        err_d    = 1'b1;
                        result_d = '0;
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_STROBE;
                    end
                end
            end
            ST_STROBE: begin
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!i_eng_busy) begin
                    result_d = i_eng_fib;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                ptr_d    = (idx_q == IDXW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
                result_d = '0;
                err_d    = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        stb_d  = (state_d == ST_STROBE);
        if (state_d == ST_DONE) begin
            ack_d[idx_d] = 1'b1;
        end
    end

    // State and registered outputs, cleared asynchronously by reset
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            idx_q    <= '0;
            n_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            ack_q    <= '0;
            stb_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            n_q      <= n_d;
            result_q <= result_d;
            err_q    <= err_d;
            ack_q    <= ack_d;
            stb_q    <= stb_d;
            busy_q   <= busy_d;
        end
    end

    assign o_ack     = ack_q;
    assign o_result  = result_q;
    assign o_err     = err_q;
    assign o_busy    = busy_q;
    assign o_eng_stb = stb_q;
    assign o_eng_n   = n_q;

endmodule

// File: tb/tb_fib_arbiter.sv
// Bench for fib_arbiter: engine model, timeline reference model, directed tests.
module tb_fib_arbiter;
    import fib_pkg::*;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int MAX_N = 47;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] n_bus = '0;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      result;
    logic                  err;
    logic                  busy;
    logic                  eng_stb;
    logic [WIDTH-1:0]      eng_n;
    logic                  eng_busy;
    logic [WIDTH-1:0]      eng_fib;
    int                    eng_cnt;
    logic [WIDTH-1:0]      eng_target;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int start  = 0;
    logic stb_seen = 1'b0;

    typedef struct {
        int         idx;
        logic [31:0] res;
        logic       err;
        int         cyc;
    } ack_t;
    ack_t log_q[$];

    int sticky  [NREQ] = '{default: 0};
    bit reraise [NREQ] = '{default: 1'b0};

    // Reference model state and the outputs it expects in the current cycle
    logic [NREQ-1:0]  exp_ack    = '0;
    logic [WIDTH-1:0] exp_result = '0;
    logic             exp_err    = 1'b0;
    logic             exp_busy   = 1'b0;
    logic             exp_stb    = 1'b0;
    logic [WIDTH-1:0] exp_eng_n  = '0;
    bit               m_active   = 1'b0;
    bit               m_in_ack   = 1'b0;
    bit               m_found    = 1'b0;
    int               m_left     = 0;
    int               m_k        = 0;
    int               m_c        = 0;
    int               m_ptr      = 0;
    logic [31:0]      m_res      = '0;
    logic             m_err      = 1'b0;
    logic [WIDTH-1:0] m_nv       = '0;

    fib_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH),
        .MAX_N (MAX_N)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_req      (req),
        .i_n        (n_bus),
        .o_ack      (ack),
        .o_result   (result),
        .o_err      (err),
        .o_busy     (busy),
        .o_eng_stb  (eng_stb),
        .o_eng_n    (eng_n),
        .i_eng_busy (eng_busy),
        .i_eng_fib  (eng_fib)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] fib_ref(input int n);
        longint a = 0;
        longint b = 1;
        longint t;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a[31:0];
    endfunction

    // Engine stand-in: busy for max(n,1) cycles after the strobe, junk on o_fib while busy
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_busy   <= 1'b0;
            eng_cnt    <= 0;
            eng_fib    <= '0;
            eng_target <= '0;
        end else if (eng_stb) begin
            eng_busy   <= 1'b1;
            eng_cnt    <= (eng_n == '0) ? 1 : int'(eng_n);
            eng_target <= fib_ref(int'(eng_n));
            eng_fib    <= 32'hDEAD_BEEF;
        end else if (eng_busy) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) begin
                eng_busy <= 1'b0;
                eng_fib  <= eng_target;
            end
        end
    end

    // Timeline model: a grant schedules an ack max(n,1)+3 cycles later (1 if rejected)
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                exp_ack = '0; exp_result = '0; exp_err = 1'b0;
                exp_busy = 1'b0; exp_stb = 1'b0; exp_eng_n = '0;
                m_active = 1'b0; m_in_ack = 1'b0; m_ptr = 0;
            end else begin
                exp_ack = '0; exp_result = '0; exp_err = 1'b0; exp_stb = 1'b0;
                if (m_active) begin
                    if (m_in_ack) begin
                        m_active = 1'b0;
                        m_in_ack = 1'b0;
                        exp_busy = 1'b0;
                    end else begin
                        m_left = m_left - 1;
                        if (m_left == 0) begin
                            exp_ack[m_k] = 1'b1;
                            exp_result   = m_res;
                            exp_err      = m_err;
                            m_in_ack     = 1'b1;
                            m_ptr        = (m_k + 1) % NREQ;
                        end
                    end
                end else if ((req != '0) && !eng_busy) begin
                    m_found = 1'b0;
                    for (int j = 0; j < NREQ; j++) begin
                        m_c = (m_ptr + j) % NREQ;
                        if (req[m_c] && !m_found) begin
                            m_found = 1'b1;
                            m_k     = m_c;
                        end
                    end
                    m_nv      = n_bus[m_k*WIDTH +: WIDTH];
                    exp_eng_n = m_nv;
                    exp_busy  = 1'b1;
                    m_active  = 1'b1;
                    if (m_nv > MAX_N) begin
                        m_err        = 1'b1;
                        m_res        = '0;
                        exp_ack[m_k] = 1'b1;
                        exp_err      = 1'b1;
                        m_in_ack     = 1'b1;
                        m_ptr        = (m_k + 1) % NREQ;
                    end else begin
                        m_err   = 1'b0;
                        m_res   = fib_ref(int'(m_nv));
                        m_left  = ((m_nv == '0) ? 1 : int'(m_nv)) + 2;
                        exp_stb = 1'b1;
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    // One clock: compare against the model, log acks, then play the requester rule
    task automatic stepCycle();
        logic [NREQ-1:0] a;
        ack_t e;
        @(negedge clk);
        checkOutput("ack",    64'(ack),     64'(exp_ack));
        checkOutput("result", 64'(result),  64'(exp_result));
        checkOutput("err",    64'(err),     64'(exp_err));
        checkOutput("busy",   64'(busy),    64'(exp_busy));
        checkOutput("stb",    64'(eng_stb), 64'(exp_stb));
        checkOutput("eng_n",  64'(eng_n),   64'(exp_eng_n));
        a = ack;
        if (eng_stb) stb_seen = 1'b1;
        if (a != '0) begin
            e.idx = 0;
            for (int k = 0; k < NREQ; k++) if (a[k]) e.idx = k;
            e.res = result;
            e.err = err;
            e.cyc = cyc;
            log_q.push_back(e);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NREQ; k++) begin
            if (reraise[k]) begin
                req[k]     = 1'b1;
                reraise[k] = 1'b0;
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (a[k]) begin
                req[k] = 1'b0;
                if (sticky[k] > 0) begin
                    sticky[k]--;
                    reraise[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic applyStimulus(input int k, input int n);
        n_bus[k*WIDTH +: WIDTH] = WIDTH'(n);
        req[k] = 1'b1;
    endtask

    task automatic waitAcks(input int count, input int budget, input string name);
        int spent = 0;
        while (log_q.size() < count && spent < budget) begin
            stepCycle();
            spent++;
        end
        if (log_q.size() < count) checkOutput({name, "_timeout"}, 64'(log_q.size()), 64'(count));
    endtask

    task automatic checkEntry(input string name, input int pos, input int idx, input logic [31:0] res, input logic e_err);
        if (log_q.size() > pos) begin
            checkOutput({name, "_idx"}, 64'(log_q[pos].idx), 64'(idx));
            checkOutput({name, "_res"}, 64'(log_q[pos].res), 64'(res));
            checkOutput({name, "_err"}, 64'(log_q[pos].err), 64'(e_err));
        end else begin
            checkOutput({name, "_present"}, 64'(log_q.size()), 64'(pos + 1));
        end
    endtask

    task automatic checkLatency(input string name, input int lat);
        if (log_q.size() > 0) checkOutput({name, "_lat"}, 64'(log_q[0].cyc - start), 64'(lat));
        else checkOutput({name, "_lat_present"}, 64'(log_q.size()), 64'(1));
    endtask

    task automatic runSingle(input string name, input int k, input int n, input logic [31:0] res, input logic e_err, input int lat);
        log_q.delete();
        start = cyc;
        applyStimulus(k, n);
        waitAcks(1, 100, name);
        checkEntry(name, 0, k, res, e_err);
        checkLatency(name, lat);
        repeat (2) stepCycle();
    endtask

    initial begin
        repeat (3) stepCycle();
        checkOutput("reset_busy",  64'(busy),  64'(0));
        checkOutput("reset_ack",   64'(ack),   64'(0));
        checkOutput("reset_eng_n", 64'(eng_n), 64'(0));
        rst = 1'b0;
        repeat (2) stepCycle();

        runSingle("n10", 0, 10, 32'd55, 1'b0, 13);
        runSingle("n0",  0, 0,  32'd0,  1'b0, 4);
        runSingle("n1",  0, 1,  32'd1,  1'b0, 4);
        runSingle("n47", 0, 47, 32'hB119_24E1, 1'b0, 50);

        stb_seen = 1'b0;
        runSingle("n48", 2, 48, 32'd0, 1'b1, 1);
        checkOutput("n48_no_stb", 64'(stb_seen), 64'(0));

        runSingle("ptr_to0", 3, 2, 32'd1, 1'b0, 5);

        log_q.delete();
        start = cyc;
        applyStimulus(0, 5); applyStimulus(1, 6); applyStimulus(2, 7); applyStimulus(3, 8);
        waitAcks(4, 300, "rr0");
        checkEntry("rr0_a", 0, 0, 32'd5,  1'b0);
        checkEntry("rr0_b", 1, 1, 32'd8,  1'b0);
        checkEntry("rr0_c", 2, 2, 32'd13, 1'b0);
        checkEntry("rr0_d", 3, 3, 32'd21, 1'b0);
        checkLatency("rr0", 8);
        repeat (2) stepCycle();

        runSingle("ptr_to2", 1, 3, 32'd2, 1'b0, 6);

        log_q.delete();
        applyStimulus(0, 5); applyStimulus(1, 6); applyStimulus(2, 7); applyStimulus(3, 8);
        waitAcks(4, 300, "rr2");
        checkEntry("rr2_a", 0, 2, 32'd13, 1'b0);
        checkEntry("rr2_b", 1, 3, 32'd21, 1'b0);
        checkEntry("rr2_c", 2, 0, 32'd5,  1'b0);
        checkEntry("rr2_d", 3, 1, 32'd8,  1'b0);
        repeat (2) stepCycle();

        log_q.delete();
        sticky[0] = 1;
        sticky[1] = 1;
        applyStimulus(0, 4); applyStimulus(1, 4);
        waitAcks(4, 300, "fair");
        checkEntry("fair_a", 0, 0, 32'd3, 1'b0);
        checkEntry("fair_b", 1, 1, 32'd3, 1'b0);
        checkEntry("fair_c", 2, 0, 32'd3, 1'b0);
        checkEntry("fair_d", 3, 1, 32'd3, 1'b0);
        repeat (3) stepCycle();

        log_q.delete();
        start = cyc;
        applyStimulus(1, 20);
        while (cyc < start + 8) stepCycle();
        rst = 1'b1;
        req[1] = 1'b0;
        #1;
        checkOutput("rst_mid_busy",   64'(busy),    64'(0));
        checkOutput("rst_mid_stb",    64'(eng_stb), 64'(0));
        checkOutput("rst_mid_eng_n",  64'(eng_n),   64'(0));
        checkOutput("rst_mid_result", 64'(result),  64'(0));
        repeat (2) stepCycle();
        rst = 1'b0;
        repeat (2) stepCycle();
        checkOutput("rst_mid_no_ack", 64'(log_q.size()), 64'(0));
        runSingle("after_rst", 1, 20, 32'd6765, 1'b0, 23);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
